dds_sweep: RTL and testbench
============================

Name: dds_sweep

Overview:
Parametrised next-generation DDS core with atomic parameter load, a programmable frequency-sweep engine (fixed, single, repeating and up/down chirp) and a pipelined external-ROM interface with an aligned valid flag. It sits between the register/control interface, which supplies the words and the set_flag pulse, and the shared waveform ROM. It drives the DAC sample path.

Parameters:
PHASE_W, 32, phase accumulator and frequency word width
ADDR_W, 12, per-waveform ROM address width (top ADDR_W bits of accumulator)
WAVE_W, 2, waveform select width (upper ROM address bits)
DATA_W, 8, sample width
DWELL_W, 16, dwell counter width
ROM_LAT, 1, ROM read latency in clocks (>=1)

Ports:
clk_dds  in  1  DDS clock
rst  in  1  asynchronous, active-high reset
dds_en  in  1  run enable; low = idle
set_flag  in  1  one-cycle pulse: load all parameter inputs into shadow registers and restart
f_start  in  PHASE_W  start (or fixed) frequency word
f_stop  in  PHASE_W  sweep end frequency word
f_step  in  PHASE_W  sweep increment per dwell period
dwell  in  DWELL_W  dwell length minus one, in clocks
p_word  in  ADDR_W  phase offset
wave_type  in  WAVE_W  waveform select
sweep_mode  in  2  0 fixed, 1 single sweep, 2 repeat sweep, 3 up/down
rom_addr  out  WAVE_W+ADDR_W  ROM address, registered
rom_data  in  DATA_W  ROM data, valid ROM_LAT clocks after rom_addr
dds_out  out  DATA_W  sample, registered
dds_valid  out  1  dds_out holds a new sample
sweep_done  out  1  one-cycle pulse when a single sweep reaches f_stop
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): all shadows, acc, f_cur and dwell counter = 0; state IDLE; rom_addr=0; dds_out=0; dds_valid=0; sweep_done=0; busy=0. Asserting rst mid-sweep aborts immediately. No partial state survives.
- Shadow load: on a clock edge with set_flag=1, latch all parameter inputs, clear acc, set f_cur=f_start, reset dwell count, set direction=up. Parameter inputs are ignored at all other times.
- States: IDLE, FIXED, SWEEP, HOLD.
  - IDLE → FIXED or SWEEP on a set_flag edge while dds_en=1 (shadow mode 0 → FIXED, else SWEEP).
  - Any state → IDLE when dds_en=0; acc is cleared, shadows are kept.
  - IDLE with dds_en=1 and no new set_flag restarts from the shadows: acc=0, f_cur=f_start.
  - set_flag in any running state restarts: shadow load, then enter FIXED or SWEEP.
- Accumulator: in FIXED, SWEEP and HOLD, acc <= acc + f_cur, modulo 2^PHASE_W. In IDLE, acc=0.
- Sweep update, SWEEP state, up direction: every dwell+1 clocks, next = f_cur + f_step, computed PHASE_W+1 bits wide (no overflow). If next >= f_stop:
  - f_cur=f_stop, then:
  - mode 1: go to HOLD, sweep_done pulses for exactly 1 clock.
  - mode 2: f_cur=f_start on the following update.
  - mode 3: flip direction.
- Down direction (mode 3 only): next = f_cur - f_step, computed signed and wide. If next <= f_start, f_cur=f_start and direction flips to up.
- f_step=0: f_cur stays constant; no done pulse is ever generated.
- f_stop<=f_start: the first update clamps to f_stop and applies the mode rule.
- HOLD: acc keeps running at f_stop until set_flag or dds_en=0.
- Address: rom_addr <= {wave_type_sh, acc[PHASE_W-1 -: ADDR_W] + p_word_sh}. The sum wraps modulo 2^ADDR_W. In IDLE, rom_addr = {wave_type_sh, p_word_sh}.
- Output pipeline: a valid bit follows rom_addr through ROM_LAT stages. When it emerges, dds_out <= rom_data and dds_valid=1; otherwise dds_out is held.
- Latency: set_flag sampled at edge T gives acc=0 at T, rom_addr of phase 0 at T+1, and the first dds_out/dds_valid at T+1+ROM_LAT+1 (T+3 for ROM_LAT=1). After that, one sample per clock while running.
- dds_valid drops to 0 ROM_LAT+1 clocks after entering IDLE (pipeline drains).

Test Plan:
- Reset mid-sweep: rst=1 asynchronously during SWEEP → all outputs 0 within the same cycle, busy=0. Releasing rst with dds_en=0 → remains IDLE.
- Fixed tone: mode 0, f_start=2^22, p_word=0, wave_type=1, ROM_LAT=1. rom_addr low 12 bits = 0,4,8,...; top bits = 1; first dds_valid at T+3; 1024 samples per period.
- Phase wrap: f_start=0, p_word=0xFFF, then 0x001 applied via set_flag → rom_addr low bits 0xFFF constant, then 0x001. An acc top field of 0xFFE with p_word=3 gives 0x001.
- Single sweep: f_start=100, f_step=50, f_stop=260, dwell=3. f_cur = 100,150,200,250,260, each change 4 clocks apart; sweep_done pulses once; HOLD at 260.
- Up/down: f_start=10, f_step=10, f_stop=30, dwell=0, mode 3 → f_cur 10,20,30,20,10,20,...
- Overflow and restart: f_start=0xFFFF_FF00, f_step=0x200, f_stop=0xFFFF_FFF0 → clamps to 0xFFFF_FFF0 (no wrap). set_flag mid-sweep → acc=0, f_cur=f_start next cycle.

Source files
------------

// File: rtl/dds_sweep_if.sv
// Bundle of control words, ROM port and sample outputs between the register
// block / waveform ROM (master) and the dds_sweep core (slave).
interface dds_sweep_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int WAVE_W  = 2,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 16
);
  logic                     dds_en;
  logic                     set_flag;
  logic [PHASE_W-1:0]       f_start;
  logic [PHASE_W-1:0]       f_stop;
  logic [PHASE_W-1:0]       f_step;
  logic [DWELL_W-1:0]       dwell;
  logic [ADDR_W-1:0]        p_word;
  logic [WAVE_W-1:0]        wave_type;
  logic [1:0]               sweep_mode;
  logic [WAVE_W+ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [DATA_W-1:0]        dds_out;
  logic                     dds_valid;
  logic                     sweep_done;
  logic                     busy;

  modport master (
    output dds_en, set_flag, f_start, f_stop, f_step, dwell, p_word,
           wave_type, sweep_mode, rom_data,
    input  rom_addr, dds_out, dds_valid, sweep_done, busy
  );

  modport slave (
    input  dds_en, set_flag, f_start, f_stop, f_step, dwell, p_word,
           wave_type, sweep_mode, rom_data,
    output rom_addr, dds_out, dds_valid, sweep_done, busy
  );
endinterface

// File: rtl/dds_sweep.sv
// DDS core: shadowed parameter load, frequency sweep engine (fixed, single,
// repeat, up/down chirp) and a latency-matched external ROM read path.
module dds_sweep #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int WAVE_W  = 2,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 16,
  parameter int ROM_LAT = 1
) (
  input  logic       clk_dds,
  input  logic       rst,
  dds_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIXED = 2'd1,
    SWEEP = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;

  logic [PHASE_W-1:0]       f_start_sh;
  logic [PHASE_W-1:0]       f_stop_sh;
  logic [PHASE_W-1:0]       f_step_sh;
  logic [DWELL_W-1:0]       dwell_sh;
  logic [ADDR_W-1:0]        p_word_sh;
  logic [WAVE_W-1:0]        wave_sh;
  logic [1:0]               mode_sh;

  logic [PHASE_W-1:0]       acc;
  logic [PHASE_W-1:0]       f_cur;
  logic [DWELL_W-1:0]       dwell_cnt;
  logic                     dir_up;

  logic [PHASE_W:0]         up_sum;
  logic signed [PHASE_W+1:0] dn_diff;
  logic [PHASE_W-1:0]       f_upd;
  logic                     dir_upd;
  logic                     hit_top;
  logic                     upd_tick;
  logic [ADDR_W-1:0]        addr_sum;

  logic [WAVE_W+ADDR_W-1:0] rom_addr_reg;
  logic [ROM_LAT:0]         vld_pipe;
  logic [DATA_W-1:0]        sample;
  logic                     valid_reg;
  logic                     done_reg;
  logic                     busy_reg;

  assign bus.rom_addr   = rom_addr_reg;
  assign bus.dds_out    = sample;
  assign bus.dds_valid  = valid_reg;
  assign bus.sweep_done = done_reg;
  assign bus.busy       = busy_reg;

  // Next sweep frequency and direction, evaluated every clock but applied only on a dwell boundary
  always_comb begin
    up_sum  = {1'b0, f_cur} + {1'b0, f_step_sh};
    dn_diff = $signed({2'b00, f_cur}) - $signed({2'b00, f_step_sh});
    f_upd   = f_cur;
    dir_upd = dir_up;
    hit_top = 1'b0;
    if (dir_up) begin
      if (up_sum >= {1'b0, f_stop_sh}) begin
        f_upd   = f_stop_sh;
        hit_top = 1'b1;
        // repeat mode parks the direction bit low to mean "restart on next update"
        dir_upd = (mode_sh == 2'd1);
      end else begin
        f_upd = up_sum[PHASE_W-1:0];
      end
    end else if (mode_sh == 2'd2) begin
      f_upd   = f_start_sh;
      dir_upd = 1'b1;
    end else if (dn_diff <= $signed({2'b00, f_start_sh})) begin
      f_upd   = f_start_sh;
      dir_upd = 1'b1;
    end else begin
      f_upd = dn_diff[PHASE_W-1:0];
    end
    upd_tick = (state == SWEEP) && (dwell_cnt == dwell_sh) &&
               (f_step_sh != {PHASE_W{1'b0}});
    addr_sum = acc[PHASE_W-1 -: ADDR_W] + p_word_sh;
  end

  // Next-state logic: disable beats set_flag, set_flag beats everything else
  always_comb begin
    state_nxt = state;
    if (!bus.dds_en) begin
      state_nxt = IDLE;
    end else if (bus.set_flag) begin
      state_nxt = (bus.sweep_mode == 2'd0) ? FIXED : SWEEP;
    end else begin
      case (state)
        IDLE:    state_nxt = (mode_sh == 2'd0) ? FIXED : SWEEP;
        FIXED:   state_nxt = FIXED;
        SWEEP: begin
          if (upd_tick && hit_top && (mode_sh == 2'd1)) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = SWEEP;
          end
        end
        HOLD:    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and busy flag
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_reg <= (state_nxt != IDLE);
    end
  end

  // Shadow registers, phase accumulator and sweep engine
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      f_start_sh <= {PHASE_W{1'b0}};
      f_stop_sh  <= {PHASE_W{1'b0}};
      f_step_sh  <= {PHASE_W{1'b0}};
      dwell_sh   <= {DWELL_W{1'b0}};
      p_word_sh  <= {ADDR_W{1'b0}};
      wave_sh    <= {WAVE_W{1'b0}};
      mode_sh    <= 2'd0;
      acc        <= {PHASE_W{1'b0}};
      f_cur      <= {PHASE_W{1'b0}};
      dwell_cnt  <= {DWELL_W{1'b0}};
      dir_up     <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.set_flag) begin
        f_start_sh <= bus.f_start;
        f_stop_sh  <= bus.f_stop;
        f_step_sh  <= bus.f_step;
        dwell_sh   <= bus.dwell;
        p_word_sh  <= bus.p_word;
        wave_sh    <= bus.wave_type;
        mode_sh    <= bus.sweep_mode;
        acc        <= {PHASE_W{1'b0}};
        f_cur      <= bus.f_start;
        dwell_cnt  <= {DWELL_W{1'b0}};
        dir_up     <= 1'b1;
      end else if (!bus.dds_en || (state == IDLE)) begin
        acc       <= {PHASE_W{1'b0}};
        f_cur     <= f_start_sh;
        dwell_cnt <= {DWELL_W{1'b0}};
        dir_up    <= 1'b1;
      end else begin
        acc <= acc + f_cur;
        if (state == SWEEP) begin
          if (dwell_cnt == dwell_sh) begin
            dwell_cnt <= {DWELL_W{1'b0}};
            if (upd_tick) begin
              f_cur    <= f_upd;
              dir_up   <= dir_upd;
              done_reg <= hit_top && (mode_sh == 2'd1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
      end
    end
  end

  // ROM address, valid shift chain matched to ROM latency, and sample capture
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      rom_addr_reg <= {(WAVE_W+ADDR_W){1'b0}};
      vld_pipe     <= {(ROM_LAT+1){1'b0}};
      sample       <= {DATA_W{1'b0}};
      valid_reg    <= 1'b0;
    end else begin
      rom_addr_reg <= {wave_sh, (state == IDLE) ? p_word_sh : addr_sum};
      vld_pipe     <= {vld_pipe[ROM_LAT-1:0], bus.dds_en && (state != IDLE)};
      valid_reg    <= vld_pipe[ROM_LAT];
      if (vld_pipe[ROM_LAT]) begin
        sample <= bus.rom_data;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep.sv
// Directed + randomized bench for dds_sweep; a frequency-list model predicts
// f_cur, rom_addr, samples, valid, done and busy cycle by cycle.
module tb_dds_sweep;
  localparam int PW = 32;
  localparam int AW = 12;
  localparam int WW = 2;
  localparam int DW = 8;
  localparam int DWW = 16;
  localparam int RL = 1;

  logic clk_dds = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  dds_sweep_if #(.PHASE_W(PW), .ADDR_W(AW), .WAVE_W(WW), .DATA_W(DW), .DWELL_W(DWW)) bus ();

  dds_sweep #(.PHASE_W(PW), .ADDR_W(AW), .WAVE_W(WW), .DATA_W(DW), .DWELL_W(DWW), .ROM_LAT(RL))
    dut (.clk_dds(clk_dds), .rst(rst), .bus(bus));

  always #5 clk_dds = ~clk_dds;

  function automatic logic [DW-1:0] rom_fn(input logic [WW+AW-1:0] a);
    logic [WW+AW-1:0] m;
    m = a * 14'd157;
    return m[7:0] ^ a[13:6];
  endfunction

  // single-cycle-latency waveform ROM
  always @(posedge clk_dds) bus.rom_data <= rom_fn(bus.rom_addr);

  longint      fq[$];
  int          done_idx;
  int          mk;
  longint      macc, mf;
  logic [13:0] ahist[$];
  bit          from_idle;
  longint      s_start, s_stop, s_step;
  int          s_dwell, s_mode;
  logic [11:0] s_p;
  logic [1:0]  s_wave;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // frequency held during each dwell period, straight from the sweep rules
  task automatic build_freqs();
    longint v, nx;
    bit up, pend;
    fq.delete();
    done_idx = -1;
    v = s_start;
    up = 1'b1;
    pend = 1'b0;
    fq.push_back(v);
    for (int i = 1; i < 1100; i++) begin
      if (s_mode == 0 || s_step == 0) begin
        v = v;
      end else if (pend) begin
        v = s_start;
        pend = 1'b0;
      end else if (up) begin
        nx = v + s_step;
        if (nx >= s_stop) begin
          v = s_stop;
          if (s_mode == 1) begin
            done_idx = i;
            fq.push_back(v);
            break;
          end else if (s_mode == 2) pend = 1'b1;
          else up = 1'b0;
        end else v = nx;
      end else begin
        nx = v - s_step;
        if (nx <= s_start) begin
          v = s_start;
          up = 1'b1;
        end else v = nx;
      end
      fq.push_back(v);
    end
  endtask

  task automatic begin_model(input bit idle_before);
    mk = 0;
    macc = 0;
    mf = s_start;
    ahist.delete();
    from_idle = idle_before;
    build_freqs();
    check("start_f_cur", dut.f_cur, s_start);
    check("start_acc", dut.acc, 0);
    check("start_busy", bus.busy, 1'b1);
    check("start_done", bus.sweep_done, 1'b0);
  endtask

  task automatic tick();
    longint prev;
    int idx;
    logic [11:0] top;
    logic [13:0] ea;
    @(posedge clk_dds);
    #1;
    mk++;
    prev = macc;
    macc = (macc + mf) & 64'hFFFF_FFFF;
    idx = mk / (s_dwell + 1);
    if (idx > fq.size() - 1) idx = fq.size() - 1;
    mf = fq[idx];
    top = 12'(prev >> 20);
    ea = {s_wave, 12'(top + s_p)};
    ahist.push_back(ea);
    check("busy", bus.busy, 1'b1);
    check("f_cur", dut.f_cur, mf);
    check("rom_addr", bus.rom_addr, ea);
    check("sweep_done", bus.sweep_done, (done_idx >= 0) && (mk == done_idx * (s_dwell + 1)));
    if (mk >= 3) begin
      check("dds_valid", bus.dds_valid, 1'b1);
      check("dds_out", bus.dds_out, rom_fn(ahist[mk-3]));
    end else if (from_idle) begin
      check("dds_valid_early", bus.dds_valid, 1'b0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input longint st, input longint sp, input longint stp, input int dw,
                       input int md, input logic [11:0] p, input logic [1:0] w);
    bit was_idle;
    bus.f_start = 32'(st);
    bus.f_stop = 32'(sp);
    bus.f_step = 32'(stp);
    bus.dwell = 16'(dw);
    bus.sweep_mode = 2'(md);
    bus.p_word = p;
    bus.wave_type = w;
    bus.set_flag = 1'b1;
    bus.dds_en = 1'b1;
    s_start = st; s_stop = sp; s_step = stp; s_dwell = dw; s_mode = md; s_p = p; s_wave = w;
    was_idle = (bus.busy == 1'b0);
    @(posedge clk_dds);
    #1;
    bus.set_flag = 1'b0;
    // parameter inputs must be ignored outside set_flag
    bus.f_start = $urandom;
    bus.f_stop = $urandom;
    bus.f_step = $urandom;
    bus.dwell = 16'($urandom);
    bus.p_word = 12'($urandom);
    bus.wave_type = 2'($urandom);
    bus.sweep_mode = 2'($urandom);
    begin_model(was_idle);
  endtask

  task automatic go_idle();
    int len;
    len = mk;
    bus.dds_en = 1'b0;
    @(posedge clk_dds);
    #1;
    check("idle_busy", bus.busy, 1'b0);
    @(posedge clk_dds);
    #1;
    check("idle_addr", bus.rom_addr, {s_wave, s_p});
    if (len >= 3) check("idle_valid_drain", bus.dds_valid, 1'b1);
    @(posedge clk_dds);
    #1;
    check("idle_valid_low", bus.dds_valid, 1'b0);
    check("idle_acc", dut.acc, 0);
  endtask

  task automatic resume();
    bus.dds_en = 1'b1;
    @(posedge clk_dds);
    #1;
    begin_model(1'b1);
  endtask

  initial begin
    longint st, sp, stp;
    bus.dds_en = 1'b0;
    bus.set_flag = 1'b0;
    bus.f_start = '0;
    bus.f_stop = '0;
    bus.f_step = '0;
    bus.dwell = '0;
    bus.p_word = '0;
    bus.wave_type = '0;
    bus.sweep_mode = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_addr", bus.rom_addr, 0);
    check("rst_out", bus.dds_out, 0);
    check("rst_valid", bus.dds_valid, 1'b0);
    check("rst_done", bus.sweep_done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    @(posedge clk_dds);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk_dds);
    #1;
    check("post_rst_busy", bus.busy, 1'b0);

    // fixed tone: 0,4,8,... with 1024 samples per period
    start(64'd1 << 22, 0, 0, 0, 0, 12'h000, 2'd1);
    run(1030);
    check("tone_wave_bits", bus.rom_addr[13:12], 2'd1);

    // phase offset, and wrap of the offset sum
    start(0, 0, 0, 0, 0, 12'hFFF, 2'd0);
    run(6);
    start(0, 0, 0, 0, 0, 12'h001, 2'd0);
    run(6);
    start(64'hFFE0_0000, 0, 0, 0, 0, 12'h003, 2'd0);
    run(2);
    check("wrap_sum", bus.rom_addr[11:0], 12'h001);
    run(4);

    // single sweep into HOLD
    start(100, 260, 50, 3, 1, 12'h010, 2'd2);
    run(30);
    check("hold_f_cur", dut.f_cur, 260);

    // up/down chirp
    start(10, 30, 10, 0, 3, 12'h000, 2'd0);
    run(12);

    // clamp without wrap, then restart mid-sweep
    start(64'hFFFF_FF00, 64'hFFFF_FFF0, 64'h200, 1, 1, 12'h005, 2'd2);
    run(8);
    check("clamp_no_wrap", dut.f_cur, 64'hFFFF_FFF0);
    start(64'h1234_5678, 64'h9000_0000, 64'h0100_0000, 2, 3, 12'h080, 2'd3);
    run(5);

    // zero step, stop below start, repeat mode
    start(500, 600, 0, 0, 1, 12'h000, 2'd1);
    run(20);
    start(1000, 200, 5, 1, 1, 12'h000, 2'd1);
    run(8);
    start(64'h0400_0000, 64'h1000_0000, 64'h0500_0000, 1, 2, 12'h123, 2'd3);
    run(20);

    go_idle();
    resume();
    run(10);

    for (int it = 0; it < 30; it++) begin
      st = $urandom;
      sp = $urandom;
      case ($urandom_range(0, 3))
        0:       stp = 0;
        1:       stp = $urandom;
        default: stp = $urandom >> $urandom_range(4, 12);
      endcase
      start(st, sp, stp, $urandom_range(0, 4), $urandom_range(0, 3), 12'($urandom), 2'($urandom));
      run($urandom_range(20, 50));
      if (it % 6 == 5) begin
        go_idle();
        resume();
        run(8);
      end
    end

    // asynchronous reset in the middle of a sweep
    start(64'h0100_0000, 64'hF000_0000, 64'h0010_0000, 0, 3, 12'h055, 2'd1);
    run(5);
    #2 rst = 1'b1;
    #1;
    check("arst_addr", bus.rom_addr, 0);
    check("arst_out", bus.dds_out, 0);
    check("arst_valid", bus.dds_valid, 1'b0);
    check("arst_done", bus.sweep_done, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_f_cur", dut.f_cur, 0);
    bus.dds_en = 1'b0;
    @(posedge clk_dds);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk_dds);
      #1;
      check("rel_busy", bus.busy, 1'b0);
      check("rel_valid", bus.dds_valid, 1'b0);
      check("rel_addr", bus.rom_addr, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
